// File: rtl/pid_pkg.sv
// Shared widths, latency and saturating clamp for the fixed-point PID controller.
package pid_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned GAIN_W  = 16;
  localparam int unsigned FRAC_W  = 8;
  localparam int unsigned ACC_W   = 32;
  localparam int unsigned LATENCY = 3;
  localparam longint      INT_LIM = 64'sd1 <<< 20;

  // Clamp a sign-extended value into [lo, hi].
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] x,
                                                   input logic signed [63:0] lo,
                                                   input logic signed [63:0] hi);
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/pid_controller_if.sv
// Sample/gain/result bus between the sensor front end, CSRs and the PID core.
interface pid_controller_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned GAIN_W = 16
);
  logic                     sample_valid_i;
  logic signed [DATA_W-1:0] setpoint_i;
  logic signed [DATA_W-1:0] feedback_i;
  logic signed [GAIN_W-1:0] kp_i;
  logic signed [GAIN_W-1:0] ki_i;
  logic signed [GAIN_W-1:0] kd_i;
  logic                     clear_i;
  logic signed [DATA_W-1:0] out_o;
  logic                     out_valid_o;
  logic                     sat_o;

  modport master (
    output sample_valid_i, setpoint_i, feedback_i, kp_i, ki_i, kd_i, clear_i,
    input  out_o, out_valid_o, sat_o
  );

  modport slave (
    input  sample_valid_i, setpoint_i, feedback_i, kp_i, ki_i, kd_i, clear_i,
    output out_o, out_valid_o, sat_o
  );
endinterface

// File: rtl/pid_sat.sv
// Combinational signed saturator: clamps IN_W-bit input to [MIN_V, MAX_V] in OUT_W bits.
module pid_sat import pid_pkg::*; #(
  parameter int unsigned IN_W  = 33,
  parameter int unsigned OUT_W = 32,
  parameter longint      MIN_V = -1,
  parameter longint      MAX_V = 1
) (
  input  logic signed [IN_W-1:0]  in_i,
  output logic signed [OUT_W-1:0] val_c,
  output logic                    sat_c
);
  logic signed [63:0] wide_c;
  logic signed [63:0] clip_c;

  always_comb begin
    wide_c = 64'(in_i);
    clip_c = sat_clamp(wide_c, MIN_V, MAX_V);
    val_c  = OUT_W'(clip_c);
    sat_c  = (clip_c != wide_c);
  end
endmodule

// File: rtl/pid_controller.sv
// Three-stage pipelined fixed-point PID: error/integrator, gain products, sum/shift/saturate.
module pid_controller #(
  parameter int unsigned DATA_W  = pid_pkg::DATA_W,
  parameter int unsigned GAIN_W  = pid_pkg::GAIN_W,
  parameter int unsigned FRAC_W  = pid_pkg::FRAC_W,
  parameter int unsigned ACC_W   = pid_pkg::ACC_W,
  parameter longint      INT_LIM = pid_pkg::INT_LIM
) (
  input logic             clk,
  input logic             rst,
  pid_controller_if.slave bus
);
  import pid_pkg::LATENCY;

  localparam int unsigned E_W   = DATA_W + 1;
  localparam int unsigned D_W   = DATA_W + 2;
  localparam int unsigned P_W   = E_W + GAIN_W;
  localparam int unsigned I_W   = ACC_W + GAIN_W;
  localparam int unsigned DV_W  = D_W + GAIN_W;
  localparam int unsigned SUM_W = ACC_W + GAIN_W + 2;
  localparam int unsigned SH_W  = SUM_W - FRAC_W;

  logic signed [E_W-1:0]    e_prev_q, e_prev_d, e_q, e_d;
  logic signed [D_W-1:0]    d_q, d_d;
  logic signed [ACC_W-1:0]  integ_q, integ_d, integ_s1_q, integ_s1_d;
  logic signed [P_W-1:0]    p_q, p_d;
  logic signed [I_W-1:0]    i_q, i_d;
  logic signed [DV_W-1:0]   dv_q, dv_d;
  logic [LATENCY-1:0]       vld_q, vld_d;
  logic signed [DATA_W-1:0] out_q, out_d;
  logic                     sat_q, sat_d;

  logic signed [E_W-1:0]    e_c, e_base_c;
  logic signed [D_W-1:0]    d_c;
  logic signed [ACC_W-1:0]  integ_base_c, integ_sat_c, integ_new_c;
  logic signed [ACC_W:0]    integ_sum_c;
  logic                     integ_clip_c;
  logic signed [SUM_W-1:0]  sum_c;
  logic signed [SH_W-1:0]   shifted_c;
  logic signed [DATA_W-1:0] out_sat_c;
  logic                     out_clip_c;

  // A clear alongside a sample makes that sample start from zero history.
  always_comb begin
    e_base_c     = bus.clear_i ? '0 : e_prev_q;
    integ_base_c = bus.clear_i ? '0 : integ_q;
    e_c          = E_W'(bus.setpoint_i) - E_W'(bus.feedback_i);
    d_c          = D_W'(e_c) - D_W'(e_base_c);
    integ_sum_c  = (ACC_W + 1)'(integ_base_c) + (ACC_W + 1)'(e_c);
    integ_new_c  = integ_clip_c ? integ_sat_c : ACC_W'(integ_sum_c);
    sum_c        = SUM_W'(p_q) + SUM_W'(i_q) + SUM_W'(dv_q);
    shifted_c    = SH_W'(sum_c >>> FRAC_W);
  end

  pid_sat #(
    .IN_W (ACC_W + 1),
    .OUT_W(ACC_W),
    .MIN_V(-INT_LIM),
    .MAX_V(INT_LIM)
  ) u_integ_sat (
    .in_i (integ_sum_c),
    .val_c(integ_sat_c),
    .sat_c(integ_clip_c)
  );

  pid_sat #(
    .IN_W (SH_W),
    .OUT_W(DATA_W),
    .MIN_V(-(longint'(1) <<< (DATA_W - 1))),
    .MAX_V((longint'(1) <<< (DATA_W - 1)) - 1)
  ) u_out_sat (
    .in_i (shifted_c),
    .val_c(out_sat_c),
    .sat_c(out_clip_c)
  );

  always_comb begin
    e_prev_d   = e_prev_q;
    integ_d    = integ_q;
    e_d        = e_q;
    d_d        = d_q;
    integ_s1_d = integ_s1_q;
    p_d        = p_q;
    i_d        = i_q;
    dv_d       = dv_q;
    out_d      = out_q;
    sat_d      = sat_q;
    vld_d      = {vld_q[LATENCY-2:0], bus.sample_valid_i};

    if (bus.sample_valid_i) begin
      e_prev_d   = e_c;
      integ_d    = integ_new_c;
      e_d        = e_c;
      d_d        = d_c;
      integ_s1_d = integ_new_c;
    end else if (bus.clear_i) begin
      e_prev_d = '0;
      integ_d  = '0;
    end

    // Gains are picked up here, one cycle after the sample.
    if (vld_q[0]) begin
      p_d  = P_W'(e_q) * P_W'(bus.kp_i);
      i_d  = I_W'(integ_s1_q) * I_W'(bus.ki_i);
      dv_d = DV_W'(d_q) * DV_W'(bus.kd_i);
    end

    if (vld_q[LATENCY-2]) begin
      out_d = out_sat_c;
      sat_d = out_clip_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_prev_q   <= '0;
      integ_q    <= '0;
      e_q        <= '0;
      d_q        <= '0;
      integ_s1_q <= '0;
      p_q        <= '0;
      i_q        <= '0;
      dv_q       <= '0;
      vld_q      <= '0;
      out_q      <= '0;
      sat_q      <= 1'b0;
    end else begin
      e_prev_q   <= e_prev_d;
      integ_q    <= integ_d;
      e_q        <= e_d;
      d_q        <= d_d;
      integ_s1_q <= integ_s1_d;
      p_q        <= p_d;
      i_q        <= i_d;
      dv_q       <= dv_d;
      vld_q      <= vld_d;
      out_q      <= out_d;
      sat_q      <= sat_d;
    end
  end

  assign bus.out_o       = out_q;
  assign bus.out_valid_o = vld_q[LATENCY-1];
  assign bus.sat_o       = sat_q;

endmodule

// File: tb/tb_pid_controller.sv
// Bench for pid_controller: directed plan plus random samples against a cycle-level arithmetic model.
module tb_pid_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pid_controller_if #(.DATA_W(16), .GAIN_W(16)) ifa ();
  pid_controller_if #(.DATA_W(16), .GAIN_W(16)) ifb ();

  pid_controller dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  pid_controller #(.INT_LIM(1000)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state (index 0: default limit, 1: limit 1000).
  longint lim[2] = '{64'sd1 <<< 20, 64'sd1000};
  longint m_integ[2];
  longint m_eprev;
  bit     pend_v;
  longint pend_e, pend_d;
  longint pend_i[2];
  int     cyc = 0;

  typedef struct {
    int     due;
    longint o0, o1;
    bit     s0, s1;
  } res_t;
  res_t res_q[$];

  logic                exp_vld;
  logic signed [15:0]  exp_out[2];
  logic                exp_sat[2];

  logic signed [15:0] g_kp, g_ki, g_kd;

  function automatic longint clampl(longint x, longint lo, longint hi);
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  task automatic cmp(string tag, logic [31:0] act, logic [31:0] exp);
    vectors++;
    assert (act === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(act), $signed(exp));
    end
  endtask

  task automatic step(bit v, logic signed [15:0] sp, logic signed [15:0] fb, bit clr, bit r);
    longint e, s, sh;
    longint o[2];
    bit     st[2];
    res_t   rr;
    ifa.sample_valid_i = v;  ifb.sample_valid_i = v;
    ifa.setpoint_i     = sp; ifb.setpoint_i     = sp;
    ifa.feedback_i     = fb; ifb.feedback_i     = fb;
    ifa.kp_i = g_kp; ifb.kp_i = g_kp;
    ifa.ki_i = g_ki; ifb.ki_i = g_ki;
    ifa.kd_i = g_kd; ifb.kd_i = g_kd;
    ifa.clear_i = clr; ifb.clear_i = clr;
    rst = r;
    @(posedge clk);
    cyc++;
    if (r) begin
      m_integ[0] = 0; m_integ[1] = 0; m_eprev = 0; pend_v = 0;
      res_q.delete();
      for (int k = 0; k < 2; k++) begin exp_out[k] = '0; exp_sat[k] = 1'b0; end
    end else begin
      if (pend_v) begin
        for (int k = 0; k < 2; k++) begin
          s  = longint'(g_kp) * pend_e + longint'(g_ki) * pend_i[k] + longint'(g_kd) * pend_d;
          sh = s >>> 8;
          o[k]  = clampl(sh, -32768, 32767);
          st[k] = (o[k] != sh);
        end
        rr.due = cyc + 1; rr.o0 = o[0]; rr.o1 = o[1]; rr.s0 = st[0]; rr.s1 = st[1];
        res_q.push_back(rr);
      end
      pend_v = v;
      if (v) begin
        e = longint'(sp) - longint'(fb);
        for (int k = 0; k < 2; k++) begin
          pend_i[k]  = clampl((clr ? 0 : m_integ[k]) + e, -lim[k], lim[k]);
          m_integ[k] = pend_i[k];
        end
        pend_d  = e - (clr ? 0 : m_eprev);
        pend_e  = e;
        m_eprev = e;
      end else if (clr) begin
        m_integ[0] = 0; m_integ[1] = 0; m_eprev = 0;
      end
    end
    exp_vld = 1'b0;
    if (res_q.size() > 0 && res_q[0].due == cyc) begin
      rr = res_q.pop_front();
      exp_vld = 1'b1;
      exp_out[0] = 16'(rr.o0); exp_out[1] = 16'(rr.o1);
      exp_sat[0] = rr.s0;      exp_sat[1] = rr.s1;
    end
    #1;
    cmp("a_valid", 32'(ifa.out_valid_o), 32'(exp_vld));
    cmp("a_out",   32'(ifa.out_o),       32'(exp_out[0]));
    cmp("a_sat",   32'(ifa.sat_o),       32'(exp_sat[0]));
    cmp("b_valid", 32'(ifb.out_valid_o), 32'(exp_vld));
    cmp("b_out",   32'(ifb.out_o),       32'(exp_out[1]));
    cmp("b_sat",   32'(ifb.sat_o),       32'(exp_sat[1]));
  endtask

  task automatic chk(int k, logic vld, logic signed [15:0] o, logic s, string tag);
    if (k == 0) begin
      cmp({tag, "_valid"}, 32'(ifa.out_valid_o), 32'(vld));
      cmp({tag, "_out"},   32'(ifa.out_o),       32'(o));
      cmp({tag, "_sat"},   32'(ifa.sat_o),       32'(s));
    end else begin
      cmp({tag, "_valid"}, 32'(ifb.out_valid_o), 32'(vld));
      cmp({tag, "_out"},   32'(ifb.out_o),       32'(o));
      cmp({tag, "_sat"},   32'(ifb.sat_o),       32'(s));
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'sd0, 16'sd0, 1'b0, 1'b0);
  endtask

  task automatic smp(logic signed [15:0] sp, logic signed [15:0] fb);
    step(1'b1, sp, fb, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic signed [15:0] rsp, rfb;
    g_kp = '0; g_ki = '0; g_kd = '0;
    step(1'b0, 16'sd0, 16'sd0, 1'b0, 1'b1);
    step(1'b0, 16'sd0, 16'sd0, 1'b0, 1'b1);
    chk(0, 1'b0, 16'sd0, 1'b0, "reset_a");
    chk(1, 1'b0, 16'sd0, 1'b0, "reset_b");

    // Proportional, including exact 3-cycle latency.
    g_kp = 16'sd256; g_ki = 16'sd0; g_kd = 16'sd0;
    smp(16'sd100, 16'sd40);
    chk(0, 1'b0, 16'sd0, 1'b0, "prop_lat1");
    idle(1);
    chk(0, 1'b0, 16'sd0, 1'b0, "prop_lat2");
    idle(1);
    chk(0, 1'b1, 16'sd60, 1'b0, "prop");
    idle(1);
    chk(0, 1'b0, 16'sd60, 1'b0, "prop_hold");

    // Integral with back-to-back samples, then clear.
    g_kp = 16'sd0; g_ki = 16'sd256;
    step(1'b0, 16'sd0, 16'sd0, 1'b1, 1'b0);
    smp(16'sd10, 16'sd0); smp(16'sd10, 16'sd0); smp(16'sd10, 16'sd0);
    chk(0, 1'b1, 16'sd10, 1'b0, "integ1");
    idle(1);
    chk(0, 1'b1, 16'sd20, 1'b0, "integ2");
    idle(1);
    chk(0, 1'b1, 16'sd30, 1'b0, "integ3");
    step(1'b0, 16'sd0, 16'sd0, 1'b1, 1'b0);
    smp(16'sd10, 16'sd0);
    idle(2);
    chk(0, 1'b1, 16'sd10, 1'b0, "integ_clear");

    // Derivative, then first sample after reset.
    g_ki = 16'sd0; g_kd = 16'sd256;
    step(1'b0, 16'sd0, 16'sd0, 1'b1, 1'b0);
    smp(16'sd0, 16'sd0); smp(16'sd50, 16'sd0); smp(16'sd50, 16'sd0);
    chk(0, 1'b1, 16'sd0, 1'b0, "deriv1");
    idle(1);
    chk(0, 1'b1, 16'sd50, 1'b0, "deriv2");
    idle(1);
    chk(0, 1'b1, 16'sd0, 1'b0, "deriv3");
    step(1'b0, 16'sd0, 16'sd0, 1'b0, 1'b1);
    smp(16'sd7, 16'sd0);
    idle(2);
    chk(0, 1'b1, 16'sd7, 1'b0, "deriv_first");

    // Output saturation in both directions.
    g_kp = 16'sd256; g_kd = 16'sd0;
    smp(16'sd30000, -16'sd30000);
    idle(2);
    chk(0, 1'b1, 16'sd32767, 1'b1, "sat_pos");
    smp(-16'sd30000, 16'sd30000);
    idle(2);
    chk(0, 1'b1, -16'sd32768, 1'b1, "sat_neg");

    // Integrator clamp on the INT_LIM=1000 instance.
    g_kp = 16'sd0; g_ki = 16'sd256;
    step(1'b0, 16'sd0, 16'sd0, 1'b1, 1'b0);
    smp(16'sd600, 16'sd0); smp(16'sd600, 16'sd0); smp(16'sd600, 16'sd0);
    chk(1, 1'b1, 16'sd600, 1'b0, "iclamp1");
    smp(-16'sd300, 16'sd0);
    chk(1, 1'b1, 16'sd1000, 1'b0, "iclamp2");
    idle(1);
    chk(1, 1'b1, 16'sd1000, 1'b0, "iclamp3");
    chk(0, 1'b1, 16'sd1800, 1'b0, "iclamp_nolim");
    idle(1);
    chk(1, 1'b1, 16'sd700, 1'b0, "iclamp4");

    // Reset with two samples in flight.
    smp(16'sd5, 16'sd0); smp(16'sd5, 16'sd0);
    step(1'b0, 16'sd0, 16'sd0, 1'b0, 1'b1);
    idle(3);
    chk(0, 1'b0, 16'sd0, 1'b0, "rst_flush");
    smp(16'sd5, 16'sd0);
    idle(2);
    chk(0, 1'b1, 16'sd5, 1'b0, "rst_resume");

    // Random traffic with occasional gain changes, clears and resets.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(7) == 0) begin
        g_kp = 16'($urandom); g_ki = 16'($urandom); g_kd = 16'($urandom);
      end
      rsp = 16'($urandom);
      rfb = 16'($urandom);
      step($urandom_range(3) != 0, rsp, rfb, $urandom_range(15) == 0, $urandom_range(63) == 0);
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pid_controller.md
Name: pid_controller

Overview:
- Fixed-point, pipelined PID controller for closed-loop control datapaths such as motor or temperature loops.
- Each accepted sample computes error = setpoint − feedback and returns a saturated control output u = Kp·e + Ki·Σe + Kd·Δe.
- Gains are run-time inputs, normally driven from a CSR block.
- Sits between a sensor/ADC front end and an actuator driver (PWM/DAC).

Parameters:
- DATA_W, 16: width of setpoint, feedback and output; signed two's complement.
- GAIN_W, 16: width of each gain; signed.
- FRAC_W, 8: fractional bits of the gains (Q(GAIN_W−FRAC_W).FRAC_W).
- ACC_W, 32: integrator width; signed.
- INT_LIM, 2**20: integrator clamp magnitude, range ±INT_LIM.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- sample_valid_i  in  1  sample strobe; one sample per asserted cycle
- setpoint_i  in  DATA_W  target value, signed
- feedback_i  in  DATA_W  measured value, signed
- kp_i  in  GAIN_W  proportional gain, signed
- ki_i  in  GAIN_W  integral gain, signed
- kd_i  in  GAIN_W  derivative gain, signed
- clear_i  in  1  clears integrator and previous error; no effect on pipeline data already in flight
- out_o  out  DATA_W  control output, signed, held between results
- out_valid_o  out  1  one-cycle pulse marking a new out_o
- sat_o  out  1  out_o was clamped; qualified by out_valid_o, held with out_o

Behaviour:
- Reset: on clk edge with rst=1, clear integ, e_prev, all pipeline registers and valid bits; out_o=0, out_valid_o=0, sat_o=0. Reset mid-pipeline discards in-flight samples, so no out_valid_o pulse results from them. rst has priority over clear_i and sample_valid_i.
- Stage 1, on the cycle sample_valid_i=1:
  - e = setpoint_i − feedback_i, DATA_W+1 bits, exact.
  - d = e − e_prev, DATA_W+2 bits.
  - integ ← clamp(integ + e, −INT_LIM, +INT_LIM), computed in ACC_W+1 bits before the clamp.
  - e_prev ← e.
  - Register e, d and the new integ value.
  - The first sample after reset/clear sees e_prev=0, so d=e.
- Stage 2: register p=kp·e, i=ki·integ_new and dv=kd·d as full-width signed products. Gains are sampled at this stage.
- Stage 3:
  - sum = p+i+dv in ACC_W+GAIN_W+2 bits.
  - shifted = sum >>> FRAC_W, arithmetic shift (truncation toward −∞).
  - out_o = clamp(shifted, −2^(DATA_W−1), 2^(DATA_W−1)−1); sat_o=1 iff clamped.
  - out_valid_o pulses.
- Latency: out_valid_o is high exactly 3 clk cycles after the cycle sample_valid_i was high. Full throughput: back-to-back samples yield back-to-back results in order.
- clear_i:
  - clear_i=1 without a sample: integ ← 0, e_prev ← 0.
  - clear_i together with a sample: that sample uses integ_old=0 and e_prev=0, so integ ← clamp(e) and e_prev ← e.
- sample_valid_i=0: integ and e_prev hold; out_o and sat_o hold their last values.
- No backpressure; the consumer must accept every out_valid_o pulse.

Decomposition:
- Package pid_pkg holds:
  - default width constants (DATA_W, GAIN_W, FRAC_W, ACC_W);
  - a saturating-clamp function used for the integrator and the output;
  - localparam LATENCY=3.
- One natural sub-module: pid_sat, a parameterised combinational signed saturator (in width, out width → value, sat flag). It is instantiated twice: integrator clamp and output clamp.

Test Plan:
- Proportional: kp=256, ki=0, kd=0 (Kd 0 isolates P); sp=100, fb=40 → out_o=60, sat_o=0, out_valid_o exactly 3 cycles after the strobe.
- Integral: kp=0, ki=256, kd=0; three back-to-back samples with e=10 → out_o=10, 20, 30 on consecutive cycles. Then clear_i=1 for one cycle and one more e=10 sample → out_o=10.
- Derivative: kp=0, ki=0, kd=256; samples with e=0, 50, 50 → out_o=0, 50, 0. First sample after reset with e=7 → out_o=7.
- Saturation: kp=256, ki=0, kd=0; sp=30000, fb=−30000 → out_o=32767, sat_o=1. Swapped inputs → out_o=−32768, sat_o=1.
- Integrator clamp: INT_LIM=1000, ki=256; repeat e=600 → out_o=600, then 1000, 1000 held. Then e=−300 → out_o=700.
- Reset mid-operation: assert rst for 1 cycle while 2 samples are in flight → no out_valid_o pulses afterwards, out_o=0. Next sample with e=5, ki=256, kp=kd=0 → out_o=5.
